hazard_scoreboard: RTL and testbench

//  Parametrised in-flight register-write scoreboard for the decode stage of the MIPS pipeline.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard scoreboard bundle: instruction fields from ID, stall/issue/forward results back.
// master = decode stage driving the instruction, slave = scoreboard.
interface hazard_scoreboard_if #(
   parameter int ADDR_W = 5,
   parameter int LAT_W  = 2,
   parameter int SEL_W  = 2
);
   logic              id_valid;
   logic [ADDR_W-1:0] id_rs_addr;
   logic              id_rs_used;
   logic [ADDR_W-1:0] id_rt_addr;
   logic              id_rt_used;
   logic              id_we;
   logic [ADDR_W-1:0] id_wr_addr;
   logic [LAT_W-1:0]  id_lat;
   logic              id_flush;

   logic              stall;
   logic              issue;
   logic [SEL_W-1:0]  fwd_rs_sel;
   logic [SEL_W-1:0]  fwd_rt_sel;
   logic [31:0]       stall_count;

   // An instruction leaves ID on a cycle where issue=1; stall=1 means ID must hold the same
   // instruction and present it again next cycle. flush kills it without stalling.
   modport master (
      output id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
             id_we, id_wr_addr, id_lat, id_flush,
      input  stall, issue, fwd_rs_sel, fwd_rt_sel, stall_count
   );

   modport slave (
      input  id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
             id_we, id_wr_addr, id_lat, id_flush,
      output stall, issue, fwd_rs_sel, fwd_rt_sel, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight register-write scoreboard: one write record per post-decode stage, producing decode
// stall and operand forward selects. Optional stall counter enabled by macro HAZARD_SB_STATS_EN.
module hazard_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 3,
   parameter int LAT_W  = 2,
   parameter int SEL_W  = 2
) (
   input logic                clk,
   input logic                rst_n,
   hazard_scoreboard_if.slave sb
);

   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(DEPTH - 1);

   logic [DEPTH:1]    slot_valid;
   logic [ADDR_W-1:0] slot_addr [1:DEPTH];
   logic [LAT_W-1:0]  slot_cnt  [1:DEPTH];

   logic [LAT_W-1:0]  lat_clamped;
   logic              rs_hazard;
   logic              rt_hazard;
   logic [SEL_W-1:0]  rs_sel;
   logic [SEL_W-1:0]  rt_sel;
   logic              stall_int;
   logic              issue_int;
   logic              record_new;

   // Clamping keeps every record forwardable by slot DEPTH at the latest.
   always_comb begin
      lat_clamped = sb.id_lat;
      if (sb.id_lat > LAT_MAX) lat_clamped = LAT_MAX;
   end

   // Scan oldest to youngest so the youngest matching slot is the last one written.
   always_comb begin
      rs_hazard = 1'b0;
      rs_sel    = '0;
      rt_hazard = 1'b0;
      rt_sel    = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (slot_valid[k] && sb.id_rs_used && (sb.id_rs_addr != '0) &&
             (slot_addr[k] == sb.id_rs_addr)) begin
            rs_hazard = (slot_cnt[k] != '0);
            rs_sel    = (slot_cnt[k] == '0) ? SEL_W'(k) : '0;
         end
         if (slot_valid[k] && sb.id_rt_used && (sb.id_rt_addr != '0) &&
             (slot_addr[k] == sb.id_rt_addr)) begin
            rt_hazard = (slot_cnt[k] != '0);
            rt_sel    = (slot_cnt[k] == '0) ? SEL_W'(k) : '0;
         end
      end
   end

   always_comb begin
      stall_int  = sb.id_valid & ~sb.id_flush & (rs_hazard | rt_hazard);
      issue_int  = rst_n & sb.id_valid & ~sb.id_flush & ~stall_int;
      record_new = issue_int & sb.id_we & (sb.id_wr_addr != '0);
   end

   // Records march one slot per clock; the count of cycles until forwardable runs down with them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            slot_addr[k] <= '0;
            slot_cnt[k]  <= '0;
         end
      end else begin
         for (int k = DEPTH; k >= 2; k--) begin
            slot_valid[k] <= slot_valid[k-1];
            slot_addr[k]  <= slot_addr[k-1];
            slot_cnt[k]   <= (slot_cnt[k-1] == '0) ? '0 : slot_cnt[k-1] - LAT_W'(1);
         end
         slot_valid[1] <= record_new;
         slot_addr[1]  <= record_new ? sb.id_wr_addr : '0;
         slot_cnt[1]   <= record_new ? lat_clamped : '0;
      end
   end

   assign sb.stall      = stall_int;
   assign sb.issue      = issue_int;
   assign sb.fwd_rs_sel = rs_sel;
   assign sb.fwd_rt_sel = rt_sel;

`ifdef HAZARD_SB_STATS_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign sb.stall_count = stall_cnt_q;
`else
   assign sb.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic against an age-based
// model of in-flight writes (slot = cycles since issue, forwardable once age-1 >= clamped latency).
module tb_hazard_scoreboard;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 3;
   localparam int LAT_W  = 2;
   localparam int SEL_W  = 2;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                lat;
      int                issued;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.ADDR_W(ADDR_W), .LAT_W(LAT_W), .SEL_W(SEL_W)) sb ();

   hazard_scoreboard #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT_W(LAT_W), .SEL_W(SEL_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .sb   (sb)
   );

   rec_t        rec_q[$];
   int          cyc = 0;
   logic        in_reset = 1'b1;
   logic [31:0] exp_count = 0;
   logic        last_stall = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
      end
   endtask

   // Youngest in-flight write to src decides: forward from its slot if ready, else hazard.
   task automatic lookup(input logic [ADDR_W-1:0] src, input logic used,
                         output int sel, output logic haz);
      int best_age;
      int best_lat;
      best_age = 0;
      best_lat = 0;
      sel = 0;
      haz = 1'b0;
      if (used && src != 0) begin
         foreach (rec_q[i]) begin
            int age;
            age = cyc - rec_q[i].issued;
            if (age >= 1 && age <= DEPTH && rec_q[i].addr == src &&
                (best_age == 0 || age < best_age)) begin
               best_age = age;
               best_lat = rec_q[i].lat;
            end
         end
      end
      if (best_age != 0) begin
         if (best_age - 1 >= best_lat) sel = best_age;
         else haz = 1'b1;
      end
   endtask

   task automatic put(input logic v, input int rs, input logic ru, input int rt, input logic rtu,
                      input logic we, input int wr, input int lat, input logic fl);
      sb.id_valid   = v;
      sb.id_rs_addr = ADDR_W'(rs);
      sb.id_rs_used = ru;
      sb.id_rt_addr = ADDR_W'(rt);
      sb.id_rt_used = rtu;
      sb.id_we      = we;
      sb.id_wr_addr = ADDR_W'(wr);
      sb.id_lat     = LAT_W'(lat);
      sb.id_flush   = fl;
   endtask

   // Called just after a falling edge with inputs applied; checks, then advances one clock.
   task automatic cycle();
      int   rs_sel;
      int   rt_sel;
      logic rs_haz;
      logic rt_haz;
      logic e_stall;
      logic e_issue;
      logic push;
      rec_t r;
      #1;
      lookup(sb.id_rs_addr, sb.id_rs_used, rs_sel, rs_haz);
      lookup(sb.id_rt_addr, sb.id_rt_used, rt_sel, rt_haz);
      e_stall = sb.id_valid && !sb.id_flush && (rs_haz || rt_haz);
      e_issue = !in_reset && sb.id_valid && !sb.id_flush && !e_stall;
      check("stall", {31'd0, sb.stall}, {31'd0, e_stall});
      check("issue", {31'd0, sb.issue}, {31'd0, e_issue});
      check("fwd_rs_sel", 32'(sb.fwd_rs_sel), 32'(rs_sel));
      check("fwd_rt_sel", 32'(sb.fwd_rt_sel), 32'(rt_sel));
      check("stall_count", sb.stall_count, exp_count);
      last_stall = e_stall;
      push = e_issue && sb.id_we && sb.id_wr_addr != 0;
      r.addr = sb.id_wr_addr;
      r.lat = (int'(sb.id_lat) > DEPTH - 1) ? DEPTH - 1 : int'(sb.id_lat);
      r.issued = cyc;
      @(posedge clk);
      if (!in_reset) begin
`ifdef HAZARD_SB_STATS_EN
         if (e_stall && exp_count != 32'hFFFF_FFFF) exp_count++;
`endif
         if (push) rec_q.push_back(r);
         cyc++;
         while (rec_q.size() > 0 && cyc - rec_q[0].issued > DEPTH) void'(rec_q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      put(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) cycle();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      in_reset = 1'b1;
      rec_q.delete();
      exp_count = 0;
      repeat (n) cycle();
      rst_n = 1'b1;
      in_reset = 1'b0;
   endtask

   initial begin
      put(1, 3, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      do_reset(2);
      cycle();

      // ALU result walks slots 1..3 then retires
      put(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle();
      put(1, 3, 1, 0, 0, 0, 0, 0, 0); repeat (4) cycle();
      idle(3);

      // load-use: one stall then forward from slot 2
      put(1, 0, 0, 0, 0, 1, 4, 1, 0); cycle();
      put(1, 0, 0, 4, 1, 0, 0, 0, 0); repeat (2) cycle();
      idle(3);

      // back-to-back writers: youngest wins
      put(1, 0, 0, 0, 0, 1, 5, 0, 0); repeat (2) cycle();
      put(1, 5, 1, 0, 0, 0, 0, 0, 0); cycle();
      idle(3);

      // $0 never tracked; flush beats a load-use stall
      put(1, 0, 0, 0, 0, 1, 0, 1, 0); cycle();
      put(1, 0, 1, 0, 1, 0, 0, 0, 0); cycle();
      put(1, 0, 0, 0, 0, 1, 6, 1, 0); cycle();
      put(1, 0, 0, 6, 1, 1, 9, 0, 1); cycle();
      put(1, 0, 0, 6, 1, 0, 0, 0, 0); cycle();
      idle(3);

      // three load-use pairs
      repeat (3) begin
         put(1, 0, 0, 0, 0, 1, 7, 1, 0); cycle();
         put(1, 7, 1, 0, 0, 0, 0, 0, 0); repeat (2) cycle();
         idle(3);
      end

      // latency beyond DEPTH-1 clamps: two stalls then forward from slot 3
      put(1, 0, 0, 0, 0, 1, 8, 3, 0); cycle();
      put(1, 8, 1, 8, 1, 0, 0, 0, 0); repeat (3) cycle();
      idle(3);

      // reset mid-flight discards records
      put(1, 0, 0, 0, 0, 1, 10, 1, 0); cycle();
      put(1, 10, 1, 0, 0, 0, 0, 0, 0);
      do_reset(1);
      cycle();
      idle(2);

      // random traffic; a stalled instruction is re-presented unchanged
      for (int i = 0; i < 3000; i++) begin
         if (!last_stall) begin
            put($urandom_range(0, 9) != 0,
                $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom_range(0, 15) == 0);
         end
         if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 2));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
